// File: rtl/inst_rom_loader_pkg.sv
// rtl/inst_rom_loader_pkg.sv - shared constants, loader state encodings and word-packing helper
package inst_rom_loader_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam int INST_BUS_W        = 32;
    localparam int INST_MEM_NUM_LOG2 = 10;

    typedef logic [INST_BUS_W-1:0] inst_bus_t;

    localparam inst_bus_t ZERO_WORD = '0;

    localparam logic [1:0] LD_IDLE  = 2'b00;
    localparam logic [1:0] LD_LOAD  = 2'b01;
    localparam logic [1:0] LD_FLUSH = 2'b10;

    // Left-justifies the n most recent bytes held in the low end of the packer.
    function automatic inst_bus_t pad_partial(input logic [23:0] pack, input logic [1:0] n);
        case (n)
            2'd1:    pad_partial = {pack[7:0], 24'h0};
            2'd2:    pad_partial = {pack[15:0], 16'h0};
            2'd3:    pad_partial = {pack[23:0], 8'h0};
            default: pad_partial = ZERO_WORD;
        endcase
    endfunction

endpackage

// File: rtl/inst_rom_mem.sv
// rtl/inst_rom_mem.sv - instruction word array, one synchronous write port and one asynchronous read port
module inst_rom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = INST_MEM_NUM_LOG2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  inst_bus_t         wdata,
    input  logic [ADDR_W-1:0] raddr,
    output inst_bus_t         rdata
);

    inst_bus_t mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction memory with zero-latency fetch and a big-endian byte-stream loader
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_W = INST_MEM_NUM_LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [31:0]     addr,
    output logic [31:0]     inst,
    input  logic            ld_start,
    input  logic            ld_valid,
    input  logic [7:0]      ld_data,
    output logic            ld_ready,
    input  logic            ld_end,
    output logic            loading,
    output logic            ovf,
    output logic [ADDR_W:0] word_cnt
);

    localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic [23:0]     pack_q, pack_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0] word_cnt_q, word_cnt_d;
    logic            ovf_q, ovf_d;

    logic            mem_we;
    inst_bus_t       mem_wdata;
    inst_bus_t       mem_rdata;
    logic            full;
    logic            fetch_en;
    logic            unused_addr_bits;

    // The count never exceeds the depth, so its MSB alone flags a full array
    // and the low bits double as the write pointer.
    assign full = word_cnt_q[ADDR_W];

    always_comb begin
        state_d    = state_q;
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_wdata  = ZERO_WORD;
        if (ld_start) begin
            state_d    = LD_LOAD;
            pack_d     = '0;
            byte_cnt_d = '0;
            word_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            case (state_q)
                LD_LOAD: begin
                    if (ld_valid) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else if (byte_cnt_q == 2'd3) begin
                            mem_we     = 1'b1;
                            mem_wdata  = {pack_q, ld_data};
                            word_cnt_d = word_cnt_q + ONE_WORD;
                            byte_cnt_d = 2'd0;
                        end else begin
                            pack_d     = {pack_q[15:0], ld_data};
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                    // End is judged on the count after this cycle's byte.
                    if (ld_end) begin
                        state_d = (byte_cnt_d == 2'd0) ? LD_IDLE : LD_FLUSH;
                    end
                end
                LD_FLUSH: begin
                    mem_we    = !full;
                    mem_wdata = pad_partial(pack_q, byte_cnt_q);
                    if (!full) begin
                        word_cnt_d = word_cnt_q + ONE_WORD;
                    end
                    byte_cnt_d = 2'd0;
                    state_d    = LD_IDLE;
                end
                LD_IDLE: begin
                    state_d = LD_IDLE;
                end
                default: begin
                    state_d = LD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= LD_IDLE;
            pack_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    inst_rom_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we && (rst != RST_ENABLE)),
        .waddr (word_cnt_q[ADDR_W-1:0]),
        .wdata (mem_wdata),
        .raddr (addr[ADDR_W+1:2]),
        .rdata (mem_rdata)
    );

    // Byte offset and upper address bits are deliberately ignored, so high addresses alias.
    assign unused_addr_bits = ^{addr[1:0], addr[31:ADDR_W+2]};

    assign loading  = (state_q != LD_IDLE);
    assign ld_ready = (state_q == LD_LOAD);
    assign ovf      = ovf_q;
    assign word_cnt = word_cnt_q;
    assign fetch_en = (rst != RST_ENABLE) && (ce == CHIP_ENABLE) && !loading;
    assign inst     = (fetch_en && (ce != CHIP_DISABLE)) ? mem_rdata : ZERO_WORD;

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - randomized and directed checks of two loader sizes against a byte-stream reference model
module tb_inst_rom_loader;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_end;

    logic [31:0] inst_a, inst_b;
    logic        ld_ready_a, ld_ready_b;
    logic        loading_a, loading_b;
    logic        ovf_a, ovf_b;
    logic [10:0] word_cnt_a;
    logic [2:0]  word_cnt_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: index 0 is the 1024-word memory, index 1 the 4-word one.
    int          m_depth [2] = '{1024, 4};
    int          m_state [2];
    int          m_bcnt  [2];
    logic [31:0] m_acc   [2];
    int          m_wcnt  [2];
    logic        m_ovf   [2];
    logic [31:0] m_mem   [2][1024];
    logic        m_wr    [2][1024];

    inst_rom_loader #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_a),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_a),
        .ld_end(ld_end), .loading(loading_a), .ovf(ovf_a), .word_cnt(word_cnt_a)
    );

    inst_rom_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_b),
        .ld_end(ld_end), .loading(loading_b), .ovf(ovf_b), .word_cnt(word_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_write(input int i, input logic [31:0] w);
        m_mem[i][m_wcnt[i]] = w;
        m_wr[i][m_wcnt[i]]  = 1'b1;
        m_wcnt[i]++;
    endtask

    // State codes here are the model's own: 0 idle, 1 collecting bytes, 2 flushing.
    task automatic model_step(input int i, input logic r, input logic s, input logic v,
                              input logic [7:0] d, input logic e);
        if (r) begin
            m_state[i] = 0; m_bcnt[i] = 0; m_acc[i] = 0; m_wcnt[i] = 0; m_ovf[i] = 1'b0;
        end else if (s) begin
            m_state[i] = 1; m_bcnt[i] = 0; m_acc[i] = 0; m_wcnt[i] = 0; m_ovf[i] = 1'b0;
        end else if (m_state[i] == 1) begin
            if (v) begin
                if (m_wcnt[i] == m_depth[i]) begin
                    m_ovf[i] = 1'b1;
                end else begin
                    m_acc[i] = (m_acc[i] << 8) | {24'h0, d};
                    m_bcnt[i]++;
                    if (m_bcnt[i] == 4) begin
                        model_write(i, m_acc[i]);
                        m_acc[i] = 0;
                        m_bcnt[i] = 0;
                    end
                end
            end
            if (e) m_state[i] = (m_bcnt[i] == 0) ? 0 : 2;
        end else if (m_state[i] == 2) begin
            if (m_wcnt[i] < m_depth[i]) model_write(i, m_acc[i] << (8 * (4 - m_bcnt[i])));
            m_acc[i] = 0;
            m_bcnt[i] = 0;
            m_state[i] = 0;
        end
    endtask

    task automatic check_fetch();
        for (int i = 0; i < 2; i++) begin
            int          idx;
            logic [31:0] got;
            got = (i == 0) ? inst_a : inst_b;
            idx = int'(addr >> 2) % m_depth[i];
            if (rst || !ce || m_state[i] != 0) begin
                check_val($sformatf("dut%0d.inst_nop", i), got, 32'h0);
            end else if (m_wr[i][idx]) begin
                check_val($sformatf("dut%0d.inst[%0d]", i, idx), got, m_mem[i][idx]);
            end
        end
    endtask

    task automatic check_status();
        check_val("a.loading",  {31'h0, loading_a},  {31'h0, m_state[0] != 0});
        check_val("a.ld_ready", {31'h0, ld_ready_a}, {31'h0, m_state[0] == 1});
        check_val("a.word_cnt", {21'h0, word_cnt_a}, m_wcnt[0]);
        check_val("a.ovf",      {31'h0, ovf_a},      {31'h0, m_ovf[0]});
        check_val("b.loading",  {31'h0, loading_b},  {31'h0, m_state[1] != 0});
        check_val("b.ld_ready", {31'h0, ld_ready_b}, {31'h0, m_state[1] == 1});
        check_val("b.word_cnt", {29'h0, word_cnt_b}, m_wcnt[1]);
        check_val("b.ovf",      {31'h0, ovf_b},      {31'h0, m_ovf[1]});
    endtask

    task automatic tick(input logic r, input logic s, input logic v, input logic [7:0] d, input logic e);
        rst = r; ld_start = s; ld_valid = v; ld_data = d; ld_end = e;
        ce = 1'($urandom_range(0, 1));
        addr = $urandom;
        #1;
        check_fetch();
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, r, s, v, d, e);
        #1;
        check_status();
    endtask

    task automatic send_bytes(input logic [7:0] b[$]);
        foreach (b[k]) tick(1'b0, 1'b0, 1'b1, b[k], 1'b0);
    endtask

    task automatic fetch_expect(input string tag, input logic [31:0] a,
                                input logic [31:0] exp_a, input logic [31:0] exp_b);
        ce = 1'b1; addr = a;
        #1;
        check_val({tag, ".a"}, inst_a, exp_a);
        check_val({tag, ".b"}, inst_b, exp_b);
    endtask

    initial begin
        logic [7:0] bq[$];
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 1024; j++) m_wr[i][j] = 1'b0;
        end
        rst = 1'b1; ce = 1'b0; addr = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_end = 1'b0;

        repeat (3) tick(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        ce = 1'b0; addr = 32'h0000_0004; #1;
        check_val("reset.inst", inst_a, 32'h0);
        check_val("reset.word_cnt", {21'h0, word_cnt_a}, 32'd0);

        // Two whole words, no flush.
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        bq = '{8'h34, 8'h01, 8'h00, 8'h20, 8'h3C, 8'h02, 8'hFF, 8'hFF};
        send_bytes(bq);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("t1.loading", {31'h0, loading_a}, 32'd0);
        check_val("t1.word_cnt", {21'h0, word_cnt_a}, 32'd2);
        fetch_expect("t1.w0", 32'h0, 32'h3401_0020, 32'h3401_0020);
        fetch_expect("t1.w1", 32'h4, 32'h3C02_FFFF, 32'h3C02_FFFF);

        // Partial trailing word goes through one flush cycle.
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_bytes(bq);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("t2.flushing", {31'h0, loading_a}, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check_val("t2.word_cnt", {21'h0, word_cnt_a}, 32'd2);
        fetch_expect("t2.w1", 32'h4, 32'h5566_0000, 32'h5566_0000);

        // Overflow of the 4-word instance.
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        bq.delete();
        for (int k = 0; k < 20; k++) bq.push_back(8'(8'h10 + k));
        send_bytes(bq);
        check_val("t3.b.word_cnt", {29'h0, word_cnt_b}, 32'd4);
        check_val("t3.b.ovf", {31'h0, ovf_b}, 32'd1);
        check_val("t3.b.ld_ready", {31'h0, ld_ready_b}, 32'd1);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        fetch_expect("t3.w3", 32'hC, 32'h1C1D_1E1F, 32'h1C1D_1E1F);
        fetch_expect("t3.alias", 32'h10, 32'h2021_2223, 32'h1011_1213);

        // Restart mid-word discards the partial bytes.
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        bq = '{8'h77, 8'h88};
        send_bytes(bq);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_bytes(bq);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check_val("t4.word_cnt", {29'h0, word_cnt_b}, 32'd1);
        check_val("t4.ovf", {31'h0, ovf_b}, 32'd0);
        fetch_expect("t4.w0", 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Reset coinciding with a word-completing byte suppresses that write.
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hA0, 8'hA1, 8'hA2};
        send_bytes(bq);
        tick(1'b1, 1'b0, 1'b1, 8'hA3, 1'b0);
        check_val("t5.loading", {31'h0, loading_a}, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        fetch_expect("t5.w0", 32'h0, 32'h0102_0304, 32'h0102_0304);
        fetch_expect("t5.w1", 32'h4, 32'h1415_1617, 32'h1415_1617);

        // Random traffic with occasional restarts, ends and resets.
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 24) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
